// File: rtl/mem_arbiter_if.sv
// Bundle of every handshake/bus signal around the two-master memory arbiter.
// Latency: none (wires only).
// Backpressure: the req_ready and mem_req_ready wires carry it; responses have no ready.
//
// Groups:
//   if_*  : instruction-fetch requester (read-only)
//   ls_*  : load/store requester
//   mem_* : shared memory port
// Modports:
//   slave  : the arbiter's view. It serves the two core masters and drives the memory port.
//   master : the environment's view. This is the core masters plus the memory model.
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // instruction fetch requester
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;

    // load/store requester
    logic                ls_req_valid;
    logic                ls_req_ready;
    logic [ADDR_W-1:0]   ls_addr;
    logic                ls_wen;
    logic [DATA_W-1:0]   ls_wdata;
    logic [DATA_W/8-1:0] ls_wmask;
    logic                ls_rsp_valid;
    logic [DATA_W-1:0]   ls_rsp_data;

    // shared memory port
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_wen;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic                mem_rsp_valid;
    logic [DATA_W-1:0]   mem_rsp_data;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (fetch / load-store) arbiter that shares one memory port, with one transaction outstanding.
// Latency: accept at T, mem_req_valid at T+1; mem_rsp_valid at R, the owner's rsp_valid at R+1.
// Backpressure: requesters are accepted only in IDLE. mem_req_ready stalls REQ with the fields held. Responses cannot be stalled.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset. It drops any in-flight transaction.
//   bus : mem_arbiter_if.slave, carrying the if_*, ls_* and mem_* handshake/data groups
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      bus
);
    localparam int MASK_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic              mem_req_vld_q, mem_req_vld_d;
    logic              if_rsp_vld_q, if_rsp_vld_d;
    logic [DATA_W-1:0] if_rsp_dat_q, if_rsp_dat_d;
    logic              ls_rsp_vld_q, ls_rsp_vld_d;
    logic [DATA_W-1:0] ls_rsp_dat_q, ls_rsp_dat_d;

    logic ls_win;
    logic if_win;

    // Round-robin grant. On a tie, LS wins unless it won the previous grant.
    // This is the only logic that is combinational from inputs to outputs.
    always_comb begin
        ls_win = 1'b0;
        if_win = 1'b0;
        if (state_q == S_IDLE) begin
            ls_win = bus.ls_req_valid && (!bus.if_req_valid || (last_q == OWN_IF));
            if_win = bus.if_req_valid && !ls_win;
        end
    end

    assign bus.if_req_ready = if_win;
    assign bus.ls_req_ready = ls_win;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        mem_req_vld_d = mem_req_vld_q;
        if_rsp_vld_d  = 1'b0;
        if_rsp_dat_d  = if_rsp_dat_q;
        ls_rsp_vld_d  = 1'b0;
        ls_rsp_dat_d  = ls_rsp_dat_q;

        case (state_q)
            S_IDLE: begin
                if (ls_win) begin
                    state_d       = S_REQ;
                    owner_d       = OWN_LS;
                    last_d        = OWN_LS;
                    addr_d        = bus.ls_addr;
                    wen_d         = bus.ls_wen;
                    wdata_d       = bus.ls_wdata;
                    wmask_d       = bus.ls_wmask;
                    mem_req_vld_d = 1'b1;
                end else if (if_win) begin
                    // Fetches are always reads, so the write fields are zeroed.
                    state_d       = S_REQ;
                    owner_d       = OWN_IF;
                    last_d        = OWN_IF;
                    addr_d        = bus.if_addr;
                    wen_d         = 1'b0;
                    wdata_d       = '0;
                    wmask_d       = '0;
                    mem_req_vld_d = 1'b1;
                end
            end

            S_REQ: begin
                // The latched fields stay put until memory takes them.
                // A response strobe here is spurious and is ignored.
                if (mem_req_vld_q && bus.mem_req_ready) begin
                    state_d       = S_WAIT;
                    mem_req_vld_d = 1'b0;
                end
            end

            S_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_d = S_IDLE;
                    if (owner_q == OWN_LS) begin
                        ls_rsp_vld_d = 1'b1;
                        ls_rsp_dat_d = bus.mem_rsp_data;
                    end else begin
                        if_rsp_vld_d = 1'b1;
                        if_rsp_dat_d = bus.mem_rsp_data;
                    end
                end
            end

            default: begin
                // Unreachable encoding. Recover to IDLE with nothing in flight.
                state_d       = S_IDLE;
                mem_req_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            owner_q       <= OWN_IF;
            last_q        <= OWN_IF;
            addr_q        <= '0;
            wen_q         <= 1'b0;
            wdata_q       <= '0;
            wmask_q       <= '0;
            mem_req_vld_q <= 1'b0;
            if_rsp_vld_q  <= 1'b0;
            if_rsp_dat_q  <= '0;
            ls_rsp_vld_q  <= 1'b0;
            ls_rsp_dat_q  <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            addr_q        <= addr_d;
            wen_q         <= wen_d;
            wdata_q       <= wdata_d;
            wmask_q       <= wmask_d;
            mem_req_vld_q <= mem_req_vld_d;
            if_rsp_vld_q  <= if_rsp_vld_d;
            if_rsp_dat_q  <= if_rsp_dat_d;
            ls_rsp_vld_q  <= ls_rsp_vld_d;
            ls_rsp_dat_q  <= ls_rsp_dat_d;
        end
    end

    assign bus.mem_req_valid = mem_req_vld_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.mem_wmask     = wmask_q;
    assign bus.if_rsp_valid  = if_rsp_vld_q;
    assign bus.if_rsp_data   = if_rsp_dat_q;
    assign bus.ls_rsp_valid  = ls_rsp_vld_q;
    assign bus.ls_rsp_data   = ls_rsp_dat_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter.
// Stimulus pushes the expected grant, memory request and response. A negedge monitor pops and compares them.
// There are also inline checks for reset values, stall stability, spurious responses and reset in WAIT.
module tb_mem_arbiter;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } mreq_t;

    typedef struct {
        logic        owner;   // 1 = LS, 0 = IF
        logic [63:0] data;
    } rsp_t;

    logic clk;
    logic rst;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic  grant_q [$];
    mreq_t mreq_q  [$];
    rsp_t  rsp_q   [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor. Outputs are sampled on the falling edge, away from the
    // rising-edge updates and the #1-after-posedge input drives.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.if_req_ready || bus.ls_req_ready) begin
                if (grant_q.size() == 0) begin
                    chk("grant_unexpected", 64'({bus.ls_req_ready, bus.if_req_ready}), 64'd0);
                end else begin
                    logic g;
                    g = grant_q.pop_front();
                    chk("grant_owner", 64'(bus.ls_req_ready), 64'(g));
                    chk("grant_one_hot", 64'(bus.if_req_ready & bus.ls_req_ready), 64'd0);
                end
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (mreq_q.size() == 0) begin
                    chk("mreq_unexpected", 64'(bus.mem_req_valid), 64'd0);
                end else begin
                    mreq_t m;
                    m = mreq_q.pop_front();
                    chk("mreq_addr",  bus.mem_addr, m.addr);
                    chk("mreq_wen",   64'(bus.mem_wen), 64'(m.wen));
                    chk("mreq_wdata", bus.mem_wdata, m.wdata);
                    chk("mreq_wmask", 64'(bus.mem_wmask), 64'(m.wmask));
                end
            end
            if (bus.if_rsp_valid || bus.ls_rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'({bus.ls_rsp_valid, bus.if_rsp_valid}), 64'd0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_owner", 64'(bus.ls_rsp_valid), 64'(r.owner));
                    chk("rsp_one_hot", 64'(bus.if_rsp_valid & bus.ls_rsp_valid), 64'd0);
                    chk("rsp_data", r.owner ? bus.ls_rsp_data : bus.if_rsp_data, r.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_txn(input logic owner, input logic [63:0] addr, input logic wen,
                            input logic [63:0] wdata, input logic [7:0] wmask);
        mreq_t m;
        grant_q.push_back(owner);
        m.addr  = addr;
        m.wen   = wen;
        m.wdata = wdata;
        m.wmask = wmask;
        mreq_q.push_back(m);
    endtask

    task automatic push_rsp(input logic owner, input logic [63:0] data);
        rsp_t r;
        r.owner = owner;
        r.data  = data;
        rsp_q.push_back(r);
    endtask

    // Memory model for one transaction. It waits (bounded) for mem_req_valid, stalls
    // for 'stall' cycles, then completes the handshake. It pulses mem_rsp_valid 'gap'+1
    // cycles after the handshake cycle, and returns in the cycle after the response.
    task automatic serve(input int stall, input int gap, input logic [63:0] data);
        int n;
        n = 0;
        while (!bus.mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("mem_req_valid_seen", 64'(bus.mem_req_valid), 64'd1);
        if (bus.mem_req_valid) begin
            repeat (stall) tick();
            bus.mem_req_ready = 1'b1;
            tick();
            bus.mem_req_ready = 1'b0;
            repeat (gap) tick();
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = data;
            tick();
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        bus.if_req_valid  = 1'b0;
        bus.if_addr       = '0;
        bus.ls_req_valid  = 1'b0;
        bus.ls_addr       = '0;
        bus.ls_wen        = 1'b0;
        bus.ls_wdata      = '0;
        bus.ls_wmask      = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;

        // ---- reset values, then a single fetch ----
        do_reset();
        @(negedge clk);
        chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_if_rsp_valid",  64'(bus.if_rsp_valid), 64'd0);
        chk("rst_ls_rsp_valid",  64'(bus.ls_rsp_valid), 64'd0);
        chk("rst_mem_addr",      bus.mem_addr, 64'd0);
        chk("rst_if_rsp_data",   bus.if_rsp_data, 64'd0);
        chk("rst_idle_no_ready", 64'({bus.if_req_ready, bus.ls_req_ready}), 64'd0);
        tick();
        push_txn(1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'h00);
        push_rsp(1'b0, 64'h0010_0073);
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0000;
        @(negedge clk);
        chk("if_ready_same_cycle", 64'(bus.if_req_ready), 64'd1);
        tick();
        bus.if_req_valid = 1'b0;
        @(negedge clk);
        chk("accept_to_mem_valid", 64'(bus.mem_req_valid), 64'd1);
        chk("accept_to_mem_addr",  bus.mem_addr, 64'h8000_0000);
        serve(0, 1, 64'h0010_0073);
        @(negedge clk);
        chk("fetch_rsp_strobe", 64'(bus.if_rsp_valid), 64'd1);
        chk("fetch_ls_quiet",   64'(bus.ls_rsp_valid), 64'd0);
        @(negedge clk);
        chk("fetch_rsp_one_cycle", 64'(bus.if_rsp_valid), 64'd0);
        chk("fetch_rsp_data_hold", bus.if_rsp_data, 64'h0010_0073);

        // ---- fairness: both masters requesting from reset ----
        rst = 1'b1;
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h1000;
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h2000;
        bus.ls_wen       = 1'b0;
        bus.ls_wdata     = 64'h55;
        bus.ls_wmask     = 8'hFF;
        push_txn(1'b1, 64'h2000, 1'b0, 64'h55, 8'hFF);
        push_rsp(1'b1, 64'hA1);
        push_txn(1'b0, 64'h1000, 1'b0, 64'h0, 8'h00);
        push_rsp(1'b0, 64'hB2);
        push_txn(1'b1, 64'h2000, 1'b0, 64'h55, 8'hFF);
        push_rsp(1'b1, 64'hC3);
        push_txn(1'b0, 64'h1000, 1'b0, 64'h0, 8'h00);
        push_rsp(1'b0, 64'hD4);
        do_reset();
        serve(0, 1, 64'hA1);
        serve(0, 1, 64'hB2);
        serve(0, 1, 64'hC3);
        serve(0, 1, 64'hD4);
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b0;
        repeat (2) tick();
        chk("fair_all_granted", 64'(grant_q.size()), 64'd0);

        // ---- stalled store: fields held while requester inputs move ----
        push_txn(1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F);
        push_rsp(1'b1, 64'h1234);
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h8000_1000;
        bus.ls_wen       = 1'b1;
        bus.ls_wdata     = 64'hDEAD_BEEF;
        bus.ls_wmask     = 8'h0F;
        tick();
        bus.ls_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ls_addr  = 64'h0BAD_0000 + 64'(i);
            bus.ls_wdata = 64'hFFFF_0000 + 64'(i);
            bus.ls_wmask = 8'hF0;
            @(negedge clk);
            chk("stall_valid_held", 64'(bus.mem_req_valid), 64'd1);
            chk("stall_addr_held",  bus.mem_addr, 64'h8000_1000);
            chk("stall_wdata_held", bus.mem_wdata, 64'hDEAD_BEEF);
            chk("stall_wmask_held", 64'(bus.mem_wmask), 64'h0F);
            tick();
        end
        serve(0, 1, 64'h1234);
        @(negedge clk);
        chk("store_ack_strobe", 64'(bus.ls_rsp_valid), 64'd1);
        bus.ls_wen = 1'b0;
        tick();

        // ---- spurious responses in IDLE and in REQ ----
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'hBAD;
        tick();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("spur_idle_no_rsp", 64'({bus.if_rsp_valid, bus.ls_rsp_valid}), 64'd0);
        chk("spur_idle_no_req", 64'(bus.mem_req_valid), 64'd0);
        tick();
        push_txn(1'b0, 64'h3000, 1'b0, 64'h0, 8'h00);
        push_rsp(1'b0, 64'hCAFE);
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h3000;
        tick();
        bus.if_req_valid  = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'hBAD2;
        tick();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("spur_req_no_rsp",  64'({bus.if_rsp_valid, bus.ls_rsp_valid}), 64'd0);
        chk("spur_req_in_req",  64'(bus.mem_req_valid), 64'd1);
        serve(0, 1, 64'hCAFE);
        @(negedge clk);
        chk("spur_then_rsp", bus.if_rsp_data, 64'hCAFE);
        tick();

        // ---- reset while in WAIT ----
        push_txn(1'b0, 64'h4000, 1'b0, 64'h0, 8'h00);
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h4000;
        tick();
        bus.if_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstwait_req_valid", 64'(bus.mem_req_valid), 64'd0);
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 64'hDEAD;
        tick();
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("rstwait_no_rsp", 64'({bus.if_rsp_valid, bus.ls_rsp_valid}), 64'd0);
        chk("rstwait_data_reset", bus.if_rsp_data, 64'd0);
        tick();
        push_txn(1'b0, 64'h5000, 1'b0, 64'h0, 8'h00);
        push_rsp(1'b0, 64'h77);
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h5000;
        @(negedge clk);
        chk("rstwait_next_accept", 64'(bus.if_req_ready), 64'd1);
        tick();
        bus.if_req_valid = 1'b0;
        serve(0, 1, 64'h77);
        repeat (3) tick();

        chk("sb_grants_drained", 64'(grant_q.size()), 64'd0);
        chk("sb_mreqs_drained",  64'(mreq_q.size()), 64'd0);
        chk("sb_rsps_drained",   64'(rsp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
